// File: rtl/decode_stage_pkg.sv
// Shared constants, FSM state type and legality check for the decode stage.
package decode_stage_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StWb,
      StTrap
   } state_e;

   // Only the integer ALU subset (OP / OP-IMM) is accepted.
   function automatic logic insn_legal(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7);
      logic ok;
      ok = 1'b0;
      if (opc == OPC_OP) begin
         ok = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end else if (opc == OPC_OP_IMM) begin
         if (f3 == 3'b001) begin
            ok = (f7 == F7_BASE);
         end else if (f3 == 3'b101) begin
            ok = (f7 == F7_BASE) || (f7 == F7_ALT);
         end else begin
            ok = 1'b1;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32 x WIDTH register file: two combinational reads, one synchronous write, x0 hardwired to 0.
module decode_stage_regfile #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic [4:0]       raddr1_i,
   input  logic [4:0]       raddr2_i,
   output logic [WIDTH-1:0] rdata1_o,
   output logic [WIDTH-1:0] rdata2_o,
   input  logic             we_i,
   input  logic [4:0]       waddr_i,
   input  logic [WIDTH-1:0] wdata_i
);

   logic [WIDTH-1:0] mem_q [32];

   always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i != 5'd0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? '0 : mem_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for RV32I register and immediate ALU ops.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned     WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic             imem_req_o,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic             imem_ack_i,
   input  logic [31:0]      imem_rdata_i,
   output logic [WIDTH-1:0] rs1_data_o,
   output logic [WIDTH-1:0] rs2_data_o,
   output logic [WIDTH-1:0] iimm_o,
   output logic [2:0]       funct3_o,
   output logic [6:0]       funct7_o,
   output logic             is_alu_reg_o,
   output logic             op_valid_o,
   input  logic [WIDTH-1:0] alu_result_i,
   output logic             trap_o,
   output logic [31:0]      instret_o
);

   state_e           state_q;
   logic [31:0]      instr_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] result_q;
   logic [31:0]      instret_q;
   logic             trap_q;
   logic             op_valid_q;
   logic [WIDTH-1:0] rs1_q, rs2_q, iimm_q;
   logic [2:0]       funct3_q;
   logic [6:0]       funct7_q;
   logic             is_alu_reg_q;

   logic [6:0]       opc;
   logic [4:0]       rd, rs1_addr, rs2_addr;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [WIDTH-1:0] rf_rdata1, rf_rdata2;
   logic             rf_we;

   assign opc      = instr_q[6:0];
   assign rd       = instr_q[11:7];
   assign f3       = instr_q[14:12];
   assign rs1_addr = instr_q[19:15];
   assign rs2_addr = instr_q[24:20];
   assign f7       = instr_q[31:25];

   assign rf_we = (state_q == StWb);

   decode_stage_regfile #(
      .WIDTH (WIDTH)
   ) u_regfile (
      .clk_i    (clk_i),
      .raddr1_i (rs1_addr),
      .raddr2_i (rs2_addr),
      .rdata1_o (rf_rdata1),
      .rdata2_o (rf_rdata2),
      .we_i     (rf_we),
      .waddr_i  (rd),
      .wdata_i  (result_q)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StFetch;
         instr_q      <= '0;
         pc_q         <= RESET_PC;
         result_q     <= '0;
         instret_q    <= '0;
         trap_q       <= 1'b0;
         op_valid_q   <= 1'b0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         iimm_q       <= '0;
         funct3_q     <= '0;
         funct7_q     <= '0;
         is_alu_reg_q <= 1'b0;
      end else begin
         op_valid_q <= 1'b0;
         unique case (state_q)
            StFetch: begin
               if (imem_ack_i) begin
                  instr_q <= imem_rdata_i;
                  state_q <= StDecode;
               end
            end
            StDecode: begin
               if (insn_legal(opc, f3, f7)) begin
                  rs1_q        <= rf_rdata1;
                  rs2_q        <= rf_rdata2;
                  iimm_q       <= {{(WIDTH-12){instr_q[31]}}, instr_q[31:20]};
                  funct3_q     <= f3;
                  funct7_q     <= f7;
                  is_alu_reg_q <= (opc == OPC_OP);
                  op_valid_q   <= 1'b1;
                  state_q      <= StExec;
               end else begin
                  trap_q  <= 1'b1;
                  state_q <= StTrap;
               end
            end
            StExec: begin
               result_q <= alu_result_i;
               state_q  <= StWb;
            end
            StWb: begin
               pc_q      <= pc_q + WIDTH'(4);
               instret_q <= instret_q + 32'd1;
               state_q   <= StFetch;
            end
            StTrap: begin
               // Terminal until reset.
               state_q <= StTrap;
            end
            default: begin
               trap_q  <= 1'b1;
               state_q <= StTrap;
            end
         endcase
      end
   end

   assign imem_req_o   = (state_q == StFetch);
   assign imem_addr_o  = pc_q;
   assign rs1_data_o   = rs1_q;
   assign rs2_data_o   = rs2_q;
   assign iimm_o       = iimm_q;
   assign funct3_o     = funct3_q;
   assign funct7_o     = funct7_q;
   assign is_alu_reg_o = is_alu_reg_q;
   assign op_valid_o   = op_valid_q;
   assign trap_o       = trap_q;
   assign instret_o    = instret_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and register width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL provide clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide imem_req  output  1  instruction fetch request.
REQ-006 SHALL provide imem_addr  output  WIDTH  fetch address (current PC).
REQ-007 SHALL provide imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 SHALL provide imem_rdata  input  32  instruction word.
REQ-009 SHALL provide rs1_data, rs2_data, Iimm  output  WIDTH each  ALU operands.
REQ-010 SHALL provide funct3 (3), funct7 (7), isALUreg (1)  outputs  ALU control.
REQ-011 SHALL provide op_valid  output  1  operands and control stable, ALU result consumed this cycle.
REQ-012 SHALL provide alu_result  input  WIDTH  combinational ALU output.
REQ-013 SHALL provide trap  output  1  sticky illegal-instruction flag.
REQ-014 SHALL provide instret  output  32  retired-instruction count.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, WB, TRAP; reset state FETCH.
REQ-016 FETCH: imem_req=1, imem_addr=PC; on imem_ack latch imem_rdata into instruction register, go DECODE; else stay.
REQ-017 imem_ack SHALL be ignored in every state other than FETCH.
REQ-018 DECODE: opcode 0110011 (OP) or 0010011 (OP-IMM) -> EXEC; any other opcode -> TRAP.
REQ-019 DECODE: OP with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000,101} -> TRAP.
REQ-020 DECODE: OP-IMM funct3=001 requiring funct7=0000000, funct3=101 requiring funct7 in {0000000,0100000}; else -> TRAP.
REQ-021 Iimm SHALL be sign-extension of instr[31:20]; funct7=instr[31:25]; funct3=instr[14:12]; isALUreg=1 only for OP.
REQ-022 rs1_data/rs2_data SHALL be register-file reads of instr[19:15]/instr[24:20], registered at end of DECODE.
REQ-023 EXEC: op_valid=1 for exactly one cycle; alu_result captured into result register; -> WB.
REQ-024 WB: write result to rd=instr[11:7] unless rd=0; PC<=PC+4 (mod 2^WIDTH, 0xFFFF_FFFC wraps to 0); instret+=1 (wraps); -> FETCH.
REQ-025 Minimum latency SHALL be 4 cycles per instruction when imem_ack is returned in the first FETCH cycle.
REQ-026 Register x0 SHALL always read 0; writes to x0 discarded.
REQ-027 Read of a register written by the previous instruction SHALL return the new value (write completes in WB before next DECODE).
REQ-028 TRAP: trap=1, imem_req=0, op_valid=0, no register/PC/instret update; held until reset.
REQ-029 Outputs SHALL hold last values outside EXEC; only op_valid qualifies them.

Reset
REQ-030 rst_n low SHALL asynchronously force: state FETCH, PC=RESET_PC, instret=0, trap=0, op_valid=0, instruction register=0, operand/control outputs=0.
REQ-031 imem_req SHALL be 1 in the first cycle after rst_n deasserts; a fetch in flight at reset is abandoned.
REQ-032 Register-file contents SHALL not be reset (except x0 reads 0).

Structure
REQ-033 Shared package SHALL hold opcode constants (OPC_OP, OPC_OP_IMM), funct7 constants, and the FSM state enum.
REQ-034 Register file SHALL be a sub-module regfile: 32xWIDTH, two combinational read ports, one synchronous write port.

Verification
REQ-035 Reset then imem_ack immediately, rdata 0x00500093 (ADDI x1,x0,5) -> op_valid with Iimm=5, funct3=000, isALUreg=0; x1=5, PC=4, instret=1 after 4 cycles.
REQ-036 Follow with 0x00108133 (ADD x2,x1,x1) -> rs1_data=rs2_data=5, isALUreg=1; x2=10.
REQ-037 0x401101B3 (SUB x3,x2,x1) -> funct7=0100000, rs1_data=10, rs2_data=5; x3=5.
REQ-038 0x00700013 (ADDI x0,x0,7) -> op_valid pulses, later read of x0 returns 0.
REQ-039 0x00000073 (ECALL) -> trap=1 after DECODE, imem_req stays 0, instret unchanged; rst_n low mid-FETCH with delayed ack -> PC=RESET_PC, trap=0.
REQ-040 RESET_PC=32'hFFFF_FFFC, one ADDI retired -> imem_addr=0 on next fetch.
